// File: rtl/pq_pkg.sv
// Shared constants and types for the shift-register priority queue family.
package pq_pkg;

  localparam int KEY_W_DEF = 8;
  localparam int VAL_W_DEF = 8;

  typedef struct packed {
    logic [KEY_W_DEF-1:0] key;
    logic [VAL_W_DEF-1:0] val;
  } kv_t;

  // Source each cell loads from on an edge; LEFT is toward the head, RIGHT toward the tail.
  typedef enum logic [1:0] {
    SEL_KEEP  = 2'd0,
    SEL_LEFT  = 2'd1,
    SEL_RIGHT = 2'd2,
    SEL_NEW   = 2'd3
  } cell_sel_e;

endpackage

// File: rtl/sr_pq_p_cell.sv
// One slot of the sorted shift-register queue: picks its next contents from
// itself, a neighbour, or the incoming entry, based only on local priority flags.
module sr_pq_p_cell
  import pq_pkg::*;
#(
  parameter int KW        = KEY_W_DEF,
  parameter int VW        = VAL_W_DEF,
  parameter bit MIN_FIRST = 1'b1,
  parameter bit IS_HEAD   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_i,
  input  logic          deq_i,
  input  logic [KW-1:0] kin_key_i,
  input  logic [VW-1:0] kin_val_i,
  input  logic          left_valid_i,
  input  logic [KW-1:0] left_key_i,
  input  logic [VW-1:0] left_val_i,
  input  logic          left_hp_i,
  input  logic          right_valid_i,
  input  logic [KW-1:0] right_key_i,
  input  logic [VW-1:0] right_val_i,
  input  logic          right_hp_i,
  output logic          valid_o,
  output logic [KW-1:0] key_o,
  output logic [VW-1:0] val_o,
  output logic          hp_o
);

  logic          valid_q, valid_d;
  logic [KW-1:0] key_q, key_d;
  logic [VW-1:0] val_q, val_d;
  cell_sel_e     sel;

  // Equal keys count as higher priority so a new entry lands behind them (FIFO ties).
  assign hp_o = valid_q && (MIN_FIRST ? (key_q <= kin_key_i) : (key_q >= kin_key_i));

  always_comb begin
    sel = SEL_KEEP;
    if (enq_i && !deq_i) begin
      if (hp_o)                      sel = SEL_KEEP;
      else if (IS_HEAD || left_hp_i) sel = SEL_NEW;
      else                           sel = SEL_LEFT;
    end else if (deq_i && !enq_i) begin
      sel = SEL_RIGHT;
    end else if (enq_i && deq_i) begin
      // Replace: head leaves, survivors shift up until the insertion point.
      if (right_hp_i)                sel = SEL_RIGHT;
      else if (IS_HEAD || hp_o)      sel = SEL_NEW;
      else                           sel = SEL_KEEP;
    end
  end

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    val_d   = val_q;
    case (sel)
      SEL_LEFT: begin
        valid_d = left_valid_i;
        key_d   = left_key_i;
        val_d   = left_val_i;
      end
      SEL_RIGHT: begin
        valid_d = right_valid_i;
        key_d   = right_key_i;
        val_d   = right_val_i;
      end
      SEL_NEW: begin
        valid_d = 1'b1;
        key_d   = kin_key_i;
        val_d   = kin_val_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      key_q   <= '0;
      val_q   <= '0;
    end else begin
      valid_q <= valid_d;
      key_q   <= key_d;
      val_q   <= val_d;
    end
  end

  assign valid_o = valid_q;
  assign key_o   = key_q;
  assign val_o   = val_q;

endmodule

// File: rtl/sr_pq_p.sv
// Single-cycle sorted priority queue built from a chain of shift-register cells;
// supports insert, remove-head and simultaneous replace every clock.
module sr_pq_p
  import pq_pkg::*;
#(
  parameter int KW        = KEY_W_DEF,
  parameter int VW        = VAL_W_DEF,
  parameter int DEPTH     = 16,
  parameter bit MIN_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KW+VW-1:0]           kvi,
  input  logic                       enq,
  input  logic                       deq,
  output logic [KW+VW-1:0]           kvo,
  output logic                       full,
  output logic                       empty,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic          v;
    logic [KW-1:0] k;
    logic [VW-1:0] d;
  } slot_t;

  slot_t          slot_w [DEPTH+1];
  logic           hp_w   [DEPTH+1];
  logic [CW-1:0]  count_q, count_d;
  logic           acc_enq, acc_deq;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign busy  = 1'b0;
  assign count = count_q;

  // Replace is legal when full; enq+deq on an empty queue degrades to a plain insert.
  assign acc_enq = enq && (!full || (deq && !empty));
  assign acc_deq = deq && !empty;

  // Virtual slot past the tail: always empty, never higher priority.
  assign slot_w[DEPTH] = '0;
  assign hp_w[DEPTH]   = 1'b0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    localparam int L = (i == 0) ? 0 : i - 1;
    logic          v_c;
    logic [KW-1:0] k_c;
    logic [VW-1:0] d_c;
    logic          hp_c;

    sr_pq_p_cell #(
      .KW        (KW),
      .VW        (VW),
      .MIN_FIRST (MIN_FIRST),
      .IS_HEAD   (i == 0)
    ) u_cell (
      .clk           (clk),
      .rst           (rst),
      .enq_i         (acc_enq),
      .deq_i         (acc_deq),
      .kin_key_i     (kvi[KW+VW-1:VW]),
      .kin_val_i     (kvi[VW-1:0]),
      .left_valid_i  (slot_w[L].v),
      .left_key_i    (slot_w[L].k),
      .left_val_i    (slot_w[L].d),
      .left_hp_i     ((i == 0) ? 1'b1 : hp_w[L]),
      .right_valid_i (slot_w[i+1].v),
      .right_key_i   (slot_w[i+1].k),
      .right_val_i   (slot_w[i+1].d),
      .right_hp_i    (hp_w[i+1]),
      .valid_o       (v_c),
      .key_o         (k_c),
      .val_o         (d_c),
      .hp_o          (hp_c)
    );

    assign slot_w[i] = '{v: v_c, k: k_c, d: d_c};
    assign hp_w[i]   = hp_c;
  end

  always_comb begin
    count_d = count_q;
    if (acc_enq && !acc_deq)      count_d = count_q + CW'(1);
    else if (acc_deq && !acc_enq) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign kvo = slot_w[0].v ? {slot_w[0].k, slot_w[0].d} : '0;

endmodule

// File: doc/sr_pq_p.md
SR_PQ_P -- requirements
Module: sr_pq_p

Interface
REQ-001 Parameter KW, 8, key width in bits.
REQ-002 Parameter VW, 8, value width in bits.
REQ-003 Parameter DEPTH, 16, number of queue slots; legal range 2 or more.
REQ-004 Parameter MIN_FIRST, 1, ordering mode: 1 = smallest key at head, 0 = largest key at head.
REQ-005 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1, reset; asynchronous, active-high.
REQ-007 Port kvi, input, KW+VW, entry to insert; key in the MSBs, value in the LSBs.
REQ-008 Port enq, input, 1, insert request for kvi.
REQ-009 Port deq, input, 1, remove-head request.
REQ-010 Port kvo, output, KW+VW, head entry, same packing as kvi.
REQ-011 Port full, output, 1, all DEPTH slots are valid.
REQ-012 Port empty, output, 1, no slot is valid.
REQ-013 Port busy, output, 1, held at 0 because every operation completes in one cycle; the port is kept for pq_if compatibility.
REQ-014 Port count, output, $clog2(DEPTH+1), number of valid entries.

Function
REQ-015 The block SHALL hold a sorted shift-register array slot[0..DEPTH-1], each slot with a valid bit; slot[0] is the head.
REQ-016 Valid slots SHALL always be contiguous from slot[0] and ordered by key according to MIN_FIRST.
REQ-017 kvo SHALL equal slot[0] when not empty and all-zero when empty; it is registered state with zero combinational latency from the slot.
REQ-018 Enq only, not full: at the next edge, kvi SHALL be placed after every valid entry that has a key of equal or higher priority; lower-priority entries shift one slot toward the tail.
REQ-019 Equal keys SHALL leave in FIFO order, with the new entry placed after existing equal keys.
REQ-020 Enq only, full: the request SHALL be ignored; no state changes and no error flag is raised.
REQ-021 Deq only, not empty: at the next edge, all entries SHALL shift one slot toward the head and the tail slot is invalidated.
REQ-022 Deq only, empty: the request SHALL be ignored.
REQ-023 Enq and deq together, not empty (replace): the head SHALL be removed and kvi inserted in sorted order among the remaining entries in one cycle; count is unchanged; this is legal when full.
REQ-024 Enq and deq together, empty: the cycle SHALL behave as enq only; count becomes 1.
REQ-025 count SHALL increment on an accepted enq, decrement on an accepted deq, and remain unchanged on a replace.
REQ-026 full SHALL be (count==DEPTH) and empty SHALL be (count==0), both derived from registered state.
REQ-027 Key comparison SHALL be unsigned over KW bits; the value field never affects ordering.
REQ-028 Every operation SHALL have single-cycle throughput, with a new request accepted on every edge.

Reset
REQ-029 Assertion of rst SHALL immediately clear all valid bits and slot contents, with count=0, empty=1, full=0, busy=0, kvo=0.
REQ-030 Assertion of rst mid-operation SHALL abort any in-flight request; enq and deq sampled while rst is high are discarded.
REQ-031 The first operation SHALL be accepted on the first rising edge after rst is deasserted.

Structure
REQ-032 pq_pkg SHALL hold the default constants KEY_W_DEF and VAL_W_DEF; the existing fixed kv_t is unchanged.
REQ-033 The module SHALL build the internal slot type locally from KW and VW.
REQ-034 Each slot SHALL be an instance of sub-module sr_pq_p_cell.
REQ-035 Each cell SHALL take its neighbours' contents and the global enq/deq/kvi signals, decide locally whether to keep, take the left neighbour, take the right neighbour, or take kvi, and store its own valid bit, key and value.
REQ-036 Cell generation SHALL use a generate loop over DEPTH.
REQ-037 RTL size SHALL be 120 to 400 lines in total.

Verification (DEPTH=4, KW=8, VW=8 unless stated)
REQ-038 Reset: assert rst asynchronously between edges -> count=0, empty=1, full=0, busy=0 and kvo=0 before the next edge.
REQ-039 Sort: enq keys 30, 10, 20 -> kvo key after each is 30, 10, 10; three deqs then give 10, 20, 30 and empty=1 after the third.
REQ-040 Overflow/underflow: enq keys 1 to 4 -> full=1; enq key 0 -> ignored, head key stays 1 and count stays 4; five deqs on a 4-entry queue -> the fifth is ignored and count stays 0.
REQ-041 Ties: enq (key 7, value 1) then (key 7, value 2) -> first deq leaves kvo=(7,2) and count=1.
REQ-042 Replace: queue {10, 20} plus enq 15 with deq in one cycle -> head 15, count 2; on an empty queue, enq 9 with deq -> head 9, count 1; on a full queue, replace succeeds and full stays 1.
REQ-043 Mode: MIN_FIRST=0, enq keys 10, 30, 20 -> head 30, and deqs give 30, 20, 10.
